// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Aligns loads, flags misaligned loads, drives the GPR write port once per instruction.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_wb_en,
    input  logic [4:0]  mem_wb_addr,
    input  logic [31:0] mem_alu_out,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_load_type,
    input  logic [31:0] mem_rdata,
    input  logic        wb_stall,
    input  logic        wb_flush,
    output logic        wb_valid,
    output logic        en_w,
    output logic [4:0]  addr_w,
    output logic [31:0] data_w,
    output logic        wb_exc_misalign,
    output logic [31:0] wb_badvaddr,
    output logic [31:0] instret
);

    logic        valid_q;
    logic        wb_en_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] alu_out_q;
    logic        is_load_q;
    logic [2:0]  load_type_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= 5'd0;
            alu_out_q   <= 32'd0;
            is_load_q   <= 1'b0;
            load_type_q <= 3'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
        end else if (wb_flush) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (wb_stall) begin
            done_q <= valid_q;
        end else begin
            valid_q     <= mem_valid;
            wb_en_q     <= mem_wb_en;
            wb_addr_q   <= mem_wb_addr;
            alu_out_q   <= mem_alu_out;
            is_load_q   <= mem_is_load;
            load_type_q <= mem_load_type;
            rdata_q     <= mem_rdata;
            done_q      <= 1'b0;
        end
    end

    logic is_lb, is_lbu, is_lh, is_lhu, is_lw;

    assign is_lb  = (load_type_q == 3'b001);
    assign is_lbu = (load_type_q == 3'b010);
    assign is_lh  = (load_type_q == 3'b011);
    assign is_lhu = (load_type_q == 3'b100);
    assign is_lw  = !(is_lb | is_lbu | is_lh | is_lhu);

    logic [1:0]  boff;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] aligned;
    logic        misaligned;

    assign boff     = alu_out_q[1:0];
    assign sel_byte = rdata_q[8*boff +: 8];
    assign sel_half = boff[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        aligned    = rdata_q;
        misaligned = 1'b0;
        unique case (1'b1)
            is_lb:  aligned = {{24{sel_byte[7]}}, sel_byte};
            is_lbu: aligned = {24'd0, sel_byte};
            is_lh: begin
                aligned    = {{16{sel_half[15]}}, sel_half};
                misaligned = alu_out_q[0];
            end
            is_lhu: begin
                aligned    = {16'd0, sel_half};
                misaligned = alu_out_q[0];
            end
            is_lw:  misaligned = |alu_out_q[1:0];
            default: ;
        endcase
    end

    assign wb_valid        = valid_q;
    assign wb_exc_misalign = valid_q & is_load_q & misaligned;
    assign wb_badvaddr     = wb_exc_misalign ? alu_out_q : 32'd0;
    assign addr_w          = wb_addr_q;
    assign data_w          = is_load_q ? aligned : alu_out_q;
    assign en_w = valid_q & wb_en_q & (wb_addr_q != 5'd0)
                & !wb_exc_misalign & !done_q;

    // Retire on the edge the instruction leaves; a stall defers it to release.
    always_ff @(posedge clk) begin
        if (!rst_n)
            instret_q <= 32'd0;
        else if (!wb_flush && !wb_stall && valid_q && !wb_exc_misalign)
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
// Immediate assertions on hand-computed vectors.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_wb_en;
    logic [4:0]  mem_wb_addr;
    logic [31:0] mem_alu_out;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_rdata;
    logic        wb_stall;
    logic        wb_flush;
    logic        wb_valid;
    logic        en_w;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        wb_exc_misalign;
    logic [31:0] wb_badvaddr;
    logic [31:0] instret;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_ret;

    wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_wb_en      (mem_wb_en),
        .mem_wb_addr    (mem_wb_addr),
        .mem_alu_out    (mem_alu_out),
        .mem_is_load    (mem_is_load),
        .mem_load_type  (mem_load_type),
        .mem_rdata      (mem_rdata),
        .wb_stall       (wb_stall),
        .wb_flush       (wb_flush),
        .wb_valid       (wb_valid),
        .en_w           (en_w),
        .addr_w         (addr_w),
        .data_w         (data_w),
        .wb_exc_misalign(wb_exc_misalign),
        .wb_badvaddr    (wb_badvaddr),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu_op(input logic [4:0] a, input logic [31:0] v);
        mem_valid   = 1'b1;
        mem_wb_en   = 1'b1;
        mem_wb_addr = a;
        mem_alu_out = v;
        mem_is_load = 1'b0;
        tick();
    endtask

    task automatic load_op(input logic [2:0] t, input logic [31:0] ea);
        mem_valid     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_addr   = 5'd9;
        mem_alu_out   = ea;
        mem_is_load   = 1'b1;
        mem_load_type = t;
        mem_rdata     = 32'h80FF_7F01;
        tick();
    endtask

    task automatic bubble();
        mem_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        mem_valid     = 1'b0;
        mem_wb_en     = 1'b0;
        mem_wb_addr   = 5'd0;
        mem_alu_out   = 32'd0;
        mem_is_load   = 1'b0;
        mem_load_type = 3'd0;
        mem_rdata     = 32'd0;
        wb_stall      = 1'b0;
        wb_flush      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_en_w", {31'd0, en_w}, 32'd0);
        chk("rst_addr_w", {27'd0, addr_w}, 32'd0);
        chk("rst_data_w", data_w, 32'd0);
        chk("rst_exc", {31'd0, wb_exc_misalign}, 32'd0);
        chk("rst_badv", wb_badvaddr, 32'd0);
        chk("rst_instret", instret, 32'd0);

        // reset during a stall
        alu_op(5'd5, 32'h0000_0055);
        chk("ms_en_w", {31'd0, en_w}, 32'd1);
        mem_valid = 1'b0;
        wb_stall  = 1'b1;
        tick();
        chk("ms_stall_en_w", {31'd0, en_w}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        wb_stall = 1'b0;
        chk("ms_rst_en_w", {31'd0, en_w}, 32'd0);
        chk("ms_rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("ms_rst_instret", instret, 32'd0);
        exp_ret = 32'd0;

        // ALU write
        alu_op(5'd3, 32'h1234_5678);
        chk("alu_en_w", {31'd0, en_w}, 32'd1);
        chk("alu_addr_w", {27'd0, addr_w}, 32'd3);
        chk("alu_data_w", data_w, 32'h1234_5678);
        chk("alu_instret0", instret, exp_ret);
        bubble();
        exp_ret++;
        chk("alu_instret1", instret, exp_ret);

        alu_op(5'd0, 32'h0000_00AA);
        chk("r0_en_w", {31'd0, en_w}, 32'd0);
        chk("r0_valid", {31'd0, wb_valid}, 32'd1);
        bubble();
        exp_ret++;
        chk("r0_instret", instret, exp_ret);

        // byte/half/word loads on 0x80FF_7F01
        load_op(3'b001, 32'h0000_1001);
        chk("lb_b1", data_w, 32'h0000_007F);
        load_op(3'b001, 32'h0000_1002);
        exp_ret++;
        chk("lb_b2", data_w, 32'hFFFF_FFFF);
        load_op(3'b010, 32'h0000_1003);
        exp_ret++;
        chk("lbu_b3", data_w, 32'h0000_0080);
        load_op(3'b011, 32'h0000_1002);
        exp_ret++;
        chk("lh_b2", data_w, 32'hFFFF_80FF);
        load_op(3'b100, 32'h0000_1002);
        exp_ret++;
        chk("lhu_b2", data_w, 32'h0000_80FF);
        load_op(3'b000, 32'h0000_1000);
        exp_ret++;
        chk("lw", data_w, 32'h80FF_7F01);
        chk("lw_en_w", {31'd0, en_w}, 32'd1);
        load_op(3'b111, 32'h0000_1000);
        exp_ret++;
        chk("lw_rsvd", data_w, 32'h80FF_7F01);
        chk("loads_instret", instret, exp_ret);

        // misaligned loads
        load_op(3'b000, 32'h0000_1002);
        exp_ret++;
        chk("mis_lw_exc", {31'd0, wb_exc_misalign}, 32'd1);
        chk("mis_lw_badv", wb_badvaddr, 32'h0000_1002);
        chk("mis_lw_en_w", {31'd0, en_w}, 32'd0);
        chk("mis_lw_instret", instret, exp_ret);
        load_op(3'b011, 32'h0000_1001);
        chk("mis_lh_exc", {31'd0, wb_exc_misalign}, 32'd1);
        chk("mis_lh_badv", wb_badvaddr, 32'h0000_1001);
        chk("mis_lh_en_w", {31'd0, en_w}, 32'd0);
        chk("mis_lh_instret", instret, exp_ret);
        load_op(3'b001, 32'h0000_1003);
        chk("lb_odd_exc", {31'd0, wb_exc_misalign}, 32'd0);
        chk("lb_odd_en_w", {31'd0, en_w}, 32'd1);
        chk("lb_odd_badv", wb_badvaddr, 32'd0);
        chk("lb_odd_instret", instret, exp_ret);
        bubble();
        exp_ret++;
        chk("post_mis_instret", instret, exp_ret);

        // 3-cycle stall on a write to $7
        alu_op(5'd7, 32'h0000_0077);
        chk("st_en_w0", {31'd0, en_w}, 32'd1);
        chk("st_addr_w", {27'd0, addr_w}, 32'd7);
        mem_valid = 1'b0;
        wb_stall  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_en_w", {31'd0, en_w}, 32'd0);
            chk("st_valid", {31'd0, wb_valid}, 32'd1);
            chk("st_instret", instret, exp_ret);
        end
        wb_stall = 1'b0;
        tick();
        exp_ret++;
        chk("st_rel_instret", instret, exp_ret);
        chk("st_rel_valid", {31'd0, wb_valid}, 32'd0);

        // flush beats stall
        alu_op(5'd4, 32'h0000_0044);
        chk("fl_valid0", {31'd0, wb_valid}, 32'd1);
        mem_valid = 1'b0;
        wb_stall  = 1'b1;
        wb_flush  = 1'b1;
        tick();
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        chk("fl_valid", {31'd0, wb_valid}, 32'd0);
        chk("fl_en_w", {31'd0, en_w}, 32'd0);
        chk("fl_instret", instret, exp_ret);

        // counter wrap
        dut.instret_q = 32'hFFFF_FFFF;
        alu_op(5'd6, 32'h0000_0066);
        bubble();
        chk("wrap_instret", instret, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback stage of the MIPS CPU. It captures a retiring instruction from the memory stage and performs little-endian load alignment with sign/zero extension. It detects misaligned loads and drives the register file's write channel (en_w, addr_w, data_w) exactly once per retired instruction. It also keeps a 32-bit retired-instruction counter for debug.

## Interface
Parameters:
- none

Ports:
- clk  in  1  main clock. All stage state updates on posedge. The register file consumes the write channel on the following negedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_wb_en  in  1  the instruction writes a GPR.
- mem_wb_addr  in  5  destination GPR.
- mem_alu_out  in  32  ALU result, or effective address for loads.
- mem_is_load  in  1  the instruction is a load.
- mem_load_type  in  3  load type encoding:
  - 000 LW
  - 001 LB
  - 010 LBU
  - 011 LH
  - 100 LHU
  - other codes are treated as LW
- mem_rdata  in  32  raw word read from data memory at {mem_alu_out[31:2],2'b00}.
- wb_stall  in  1  hold the current WB contents.
- wb_flush  in  1  kill the incoming instruction.
- wb_valid  out  1  the stage holds an instruction.
- en_w  out  1  register file write enable.
- addr_w  out  5  register file write address.
- data_w  out  32  register file write data.
- wb_exc_misalign  out  1  the held load is misaligned.
- wb_badvaddr  out  32  faulting address, valid when wb_exc_misalign=1, otherwise 0.
- instret  out  32  count of retired non-excepting instructions.

## Operation
- Stage register:
  - Contents: valid, wb_en, wb_addr, alu_out, is_load, load_type, rdata, done.
  - On posedge with rst_n=1, the first matching rule applies:
    - wb_flush=1 → valid←0 and done←0. Other fields are don't-care.
    - else wb_stall=1 → all fields hold, and done←valid.
    - else load all fields from mem_*, with valid←mem_valid and done←0.
- Misalign check:
  - LW, or a reserved code: misaligned when alu_out[1:0]≠0.
  - LH/LHU: misaligned when alu_out[0]≠0.
  - LB/LBU: never misaligned.
  - Non-loads: never misaligned.
  - wb_exc_misalign = valid & is_load & misaligned.
- Load alignment, little-endian, byte offset b = alu_out[1:0]:
  - LB/LBU select rdata[8b+7:8b].
  - LH/LHU select rdata[16·b[1]+15:16·b[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes rdata through unchanged.
- data_w = is_load ? aligned data : alu_out.
- addr_w = wb_addr.
- Write suppression:
  - en_w = valid & wb_en & (wb_addr≠0) & !wb_exc_misalign & !done.
  - done makes the write happen only in the first cycle of occupancy, so a stall never re-writes.
- When en_w=0, addr_w and data_w still reflect the register contents. The register file ignores them.
- instret increments by 1 (mod 2^32, wraps to 0) on any posedge that meets all of:
  - rst_n=1
  - wb_flush=0
  - wb_stall=0
  - valid=1
  - wb_exc_misalign=0

  The count covers instructions with or without a GPR write.

## Timing
- Reset (rst_n=0 at a posedge) forces:
  - valid, done, and all stage fields to 0
  - instret to 0
- The outputs follow combinationally, so after reset wb_valid=0, en_w=0, addr_w=0, data_w=0, wb_exc_misalign=0, wb_badvaddr=0 and instret=0.
- Reset overrides flush and stall, and aborts any pending write.
- Latency: an instruction is present at MEM in cycle N and captured at the posedge ending N.
  - en_w/addr_w/data_w are valid throughout cycle N+1.
  - The register file writes at the negedge mid-N+1.
  - A same-cycle ID read in the second half of N+1 sees the new value. No forwarding from WB is required.
- Flush has priority over stall. With both asserted, the stage empties.
- While stalled for k cycles, en_w is high only in the first cycle and instret does not change. instret increments once, on the releasing edge.
- Misaligned load: en_w=0 and wb_exc_misalign=1 for the whole occupancy. instret is not incremented. Redirecting the pipeline is the exception unit's job.
- All outputs are pure functions of the stage register; there is no input-to-output combinational path.

## Test plan
- Reset mid-stall:
  - Stimulus: hold a valid ALU write to $5 with wb_stall=1, then assert rst_n=0 for one edge.
  - Required: en_w=0, wb_valid=0 and instret=0 at the next cycle.
- ALU write:
  - Stimulus: mem_wb_addr=3, mem_alu_out=0x1234_5678, non-load.
  - Required: one cycle later en_w=1, addr_w=3, data_w=0x1234_5678. Afterwards instret=1.
  - Repeat with mem_wb_addr=0 → en_w=0 while instret still increments.
- Byte/half loads:
  - Stimulus: mem_rdata=0x80FF_7F01.
  - Required data_w:
    - LB, b=1 → 0x0000_007F
    - LB, b=2 → 0xFFFF_FFFF
    - LBU, b=3 → 0x0000_0080
    - LH, b=2 → 0xFFFF_80FF
    - LHU, b=2 → 0x0000_80FF
    - LW → 0x80FF_7F01
- Misalign:
  - Stimulus: LW at 0x1002, then LH at 0x1001.
  - Required for each: wb_exc_misalign=1, wb_badvaddr equal to the address, en_w=0, instret unchanged.
  - Stimulus: LB at 0x1003.
  - Required: en_w=1 with no exception.
- Stall/flush:
  - Stimulus: stall 3 cycles on a write to $7.
  - Required: en_w=1 only in the first cycle, instret +1 on release.
  - Stimulus: wb_flush=1 together with wb_stall=1.
  - Required: next cycle wb_valid=0.
  - Stimulus: instret=0xFFFF_FFFF plus one retirement.
  - Required: instret=0.
